// File: rtl/gate_vector_checker_if.sv
// Bundles the control/status handshake and the gate-under-test stimulus/response
// lines of gate_vector_checker. The slave side is the checker itself; the master
// side is whoever commands runs and hosts the gate (usually a bench).
interface gate_vector_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             clr_err;
    logic             dut_a;
    logic             dut_b;
    logic             dut_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [3:0]       fail_vec;
    logic [ERR_W-1:0] err_count;

    modport slave (
        input  start, clr_err, dut_y,
        output dut_a, dut_b, busy, done, pass, fail_vec, err_count
    );

    modport master (
        output start, clr_err, dut_y,
        input  dut_a, dut_b, busy, done, pass, fail_vec, err_count
    );
endinterface

// File: rtl/gate_vector_checker.sv
// Stimulus/response checker for a 2-input gate. A run walks {a,b} through
// 00,01,10,11, waits SETTLE_CYCLES after each drive, samples dut_y against the
// TRUTH table, and reports per-vector failures, pass/done and a saturating
// cumulative error count.
module gate_vector_checker #(
    parameter logic [3:0] TRUTH         = 4'b1000,
    parameter int         SETTLE_CYCLES = 2,
    parameter int         ERR_W         = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    gate_vector_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t           state;
    state_t           state_next;
    logic [1:0]       idx;
    logic [7:0]       cnt;
    logic             dut_a;
    logic             dut_b;
    logic             pass;
    logic [3:0]       fail_vec;
    logic [ERR_W-1:0] err_count;

    logic             start_run;
    logic             cnt_dec;
    logic             do_sample;
    logic             finish;
    logic             mismatch;

    // The response is wrong when it disagrees with the table entry for the vector on the pins.
    assign mismatch = (bus.dut_y != TRUTH[idx]);

    // State register; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the per-state datapath strobes.
    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        cnt_dec    = 1'b0;
        do_sample  = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    start_run  = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 8'd0) begin
                    state_next = SAMPLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SAMPLE: begin
                do_sample = 1'b1;
                if (idx == 2'd3) begin
                    state_next = DONE;
                end else begin
                    state_next = SETTLE;
                end
            end
            DONE: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Vector index, stimulus pins, settle counter and per-run result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= 2'd0;
            cnt      <= 8'd0;
            dut_a    <= 1'b0;
            dut_b    <= 1'b0;
            fail_vec <= 4'b0000;
            pass     <= 1'b0;
        end else if (start_run) begin
            idx      <= 2'd0;
            cnt      <= SETTLE_LOAD;
            dut_a    <= 1'b0;
            dut_b    <= 1'b0;
            fail_vec <= 4'b0000;
            pass     <= 1'b0;
        end else if (cnt_dec) begin
            cnt <= cnt - 8'd1;
        end else if (do_sample) begin
            if (mismatch) begin
                fail_vec[idx] <= 1'b1;
            end
            if (idx != 2'd3) begin
                idx            <= idx + 2'd1;
                {dut_a, dut_b} <= idx + 2'd1;
                cnt            <= SETTLE_LOAD;
            end
        end else if (finish) begin
            pass <= (fail_vec == 4'b0000);
        end
    end

    // Cumulative mismatch counter; a clear on the same edge as a mismatch leaves it at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (bus.clr_err) begin
            err_count <= '0;
        end else if (do_sample && mismatch && (err_count != ERR_MAX)) begin
            err_count <= err_count + 1'b1;
        end
    end

    assign bus.dut_a     = dut_a;
    assign bus.dut_b     = dut_b;
    assign bus.busy      = (state == SETTLE) || (state == SAMPLE);
    assign bus.done      = (state == DONE);
    assign bus.pass      = pass;
    assign bus.fail_vec  = fail_vec;
    assign bus.err_count = err_count;

endmodule
